// File: rtl/vga_text_pkg.sv
// Shared constants, FSM encoding and glyph bitmaps for the VGA text pixel generator.
package vga_text_pkg;

  localparam int unsigned COLS   = 80;
  localparam int unsigned ROWS   = 30;
  localparam int unsigned CELLS  = 2400;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned RGB_W  = 12;

  localparam logic [CODE_W-1:0] CH_COLON = 4'd10;
  localparam logic [CODE_W-1:0] CH_SLASH = 4'd11;
  localparam logic [CODE_W-1:0] CH_SPACE = 4'd12;
  localparam logic [CODE_W-1:0] CH_A     = 4'd13;
  localparam logic [CODE_W-1:0] CH_P     = 4'd14;
  localparam logic [CODE_W-1:0] CH_M     = 4'd15;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    return (ADDR_W'(row) << 6) + (ADDR_W'(row) << 4) + ADDR_W'(col);
  endfunction

  // 16 rows of 8 pixels per glyph; row 0 is the most significant byte, pixel 0 the MSB of a row.
  function automatic logic [127:0] glyph(input logic [CODE_W-1:0] code);
    case (code)
      4'd0:     return 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
      4'd1:     return 128'h0000_1838_7818_1818_1818_187E_0000_0000;
      4'd2:     return 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
      4'd3:     return 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
      4'd4:     return 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
      4'd5:     return 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
      4'd6:     return 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
      4'd7:     return 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
      4'd8:     return 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
      4'd9:     return 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
      CH_COLON: return 128'h0000_0000_1818_0000_0018_1800_0000_0000;
      CH_SLASH: return 128'h0000_0000_0206_0C18_3060_C080_0000_0000;
      CH_A:     return 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
      CH_P:     return 128'h0000_FC66_6666_7C60_6060_60F0_0000_0000;
      CH_M:     return 128'h0000_C6EE_FEFE_D6C6_C6C6_C6C6_0000_0000;
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/font_rom_16.sv
// 256x8 synchronous glyph ROM, address {code,row}, output registered on each pixel tick.
module font_rom_16
  import vga_text_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] addr,
  output logic [7:0] data
);

  logic [127:0] bits_c;
  logic [7:0]   row_c;

  always_comb begin
    bits_c = glyph(addr[7:4]);
    row_c  = bits_c[{4'(4'd15 - addr[3:0]), 3'b000} +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   data <= '0;
    else if (en) data <= row_c;
  end

endmodule

// File: rtl/vga_text_pixel_gen.sv
// 80x30 text-mode pixel generator with a two-tick RGB pipeline and aligned sync outputs.
// Optional cursor blink is enabled by defining CURSOR_BLINK_EN.
module vga_text_pixel_gen
  import vga_text_pkg::*;
#(
  parameter logic [RGB_W-1:0] FG_COLOR  = 12'hFFF,
  parameter logic [RGB_W-1:0] BG_COLOR  = 12'h000,
  parameter int unsigned      BLINK_DIV = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p_tick,
  input  logic             video_on,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [9:0]       pixel_x,
  input  logic [9:0]       pixel_y,
  input  logic             wr_en,
  input  logic [6:0]       wr_col,
  input  logic [4:0]       wr_row,
  input  logic [3:0]       wr_char,
  input  logic [6:0]       cur_col,
  input  logic [4:0]       cur_row,
  output logic             busy,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb
);

  state_t              state;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [CODE_W-1:0]   mem [CELLS];

  logic                clearing_c, wr_ok_c, mem_we_c;
  logic [ADDR_W-1:0]   mem_wa_c, rd_addr_c;
  logic [CODE_W-1:0]   mem_wd_c, rd_code_c;
  logic [4:0]          rd_row_c;
  logic [6:0]          rd_col_c;
  logic                inv_c;

  logic [7:0]          font_row;
  logic [2:0]          x_d1;
  logic                von_d1, clr_d1, hs_d1, vs_d1, inv_d1;
  logic                glyph_bit_c;

  // Post-reset sweep writes a space into every cell, then the FSM parks in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_ptr == ADDR_W'(CELLS - 1)) begin
            state <= ST_RUN;
            busy  <= 1'b0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        ST_RUN:  busy <= 1'b0;
        default: state <= ST_CLEAR;
      endcase
    end
  end

  always_comb begin
    clearing_c = (state == ST_CLEAR);
    wr_ok_c    = (state == ST_RUN) && wr_en && (wr_col < 7'(COLS)) && (wr_row < 5'(ROWS));
    mem_we_c   = clearing_c || wr_ok_c;
    mem_wa_c   = clearing_c ? clr_ptr : cell_addr(wr_row, wr_col);
    mem_wd_c   = clearing_c ? CH_SPACE : wr_char;
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_wa_c] <= mem_wd_c;
  end

  // Blanking coordinates can land past the last cell; those reads are forced to a space.
  always_comb begin
    rd_row_c  = pixel_y[8:4];
    rd_col_c  = pixel_x[9:3];
    rd_addr_c = cell_addr(rd_row_c, rd_col_c);
    rd_code_c = (rd_addr_c < ADDR_W'(CELLS)) ? mem[rd_addr_c] : CH_SPACE;
  end

`ifdef CURSOR_BLINK_EN
  logic [BLINK_DIV-1:0] frame_cnt;
  logic                 blink_phase;
  logic                 vs_prev;
  logic                 unused_y;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      vs_prev     <= 1'b0;
    end else begin
      vs_prev <= vsync_in;
      if (vsync_in && !vs_prev) begin
        frame_cnt <= BLINK_DIV'(frame_cnt + 1'b1);
        if (&frame_cnt) blink_phase <= !blink_phase;
      end
    end
  end

  assign inv_c    = blink_phase && (rd_col_c == cur_col) && (rd_row_c == cur_row);
  assign unused_y = pixel_y[9];
`else
  logic unused_y;
  assign inv_c    = 1'b0;
  assign unused_y = ^{pixel_y[9], cur_col, cur_row, 1'(BLINK_DIV)};
`endif

  font_rom_16 u_font (
    .clk   (clk),
    .reset (reset),
    .en    (p_tick),
    .addr  ({rd_code_c, pixel_y[3:0]}),
    .data  (font_row)
  );

  // Stage 1: carry pixel context alongside the ROM lookup.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_d1   <= '0;
      von_d1 <= 1'b0;
      clr_d1 <= 1'b0;
      hs_d1  <= 1'b0;
      vs_d1  <= 1'b0;
      inv_d1 <= 1'b0;
    end else if (p_tick) begin
      x_d1   <= pixel_x[2:0];
      von_d1 <= video_on;
      clr_d1 <= clearing_c;
      hs_d1  <= hsync_in;
      vs_d1  <= vsync_in;
      inv_d1 <= inv_c;
    end
  end

  assign glyph_bit_c = font_row[3'(3'd7 - x_d1)] ^ inv_d1;

  // Stage 2: colour select and sync alignment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb   <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else if (p_tick) begin
      hsync <= hs_d1;
      vsync <= vs_d1;
      if (!von_d1)         rgb <= '0;
      else if (clr_d1)     rgb <= BG_COLOR;
      else if (glyph_bit_c) rgb <= FG_COLOR;
      else                 rgb <= BG_COLOR;
    end
  end

endmodule
